// File: rtl/fetch_unit_pkg.sv
// Shared RV32I pipeline definitions: bubble instruction, opcodes, fetch FSM encoding and the
// IF/ID payload that the decode stage consumes.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef logic [1:0] fetch_state_e;
  localparam fetch_state_e ISSUE = 2'd0;
  localparam fetch_state_e WAIT  = 2'd1;
  localparam fetch_state_e DROP  = 2'd2;
  localparam fetch_state_e HELD  = 2'd3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble that keeps pc.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  logic   stall_i,
  input  logic   load_i,
  input  if_id_t load_data_i,
  output if_id_t if_id_o
);

  if_id_t if_id_q, if_id_d;

  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d = '{inst: NOP_INST, pc: 32'h0, valid: 1'b0};
    end else if (stall_i) begin
      if_id_d = if_id_q;
    end else if (load_i) begin
      if_id_d       = load_data_i;
      if_id_d.valid = 1'b1;
    end else begin
      if_id_d.inst  = NOP_INST;
      if_id_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= '{inst: NOP_INST, pc: 32'h0, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM and redirect handling,
// feeding the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_target,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic         redir;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         req;
  logic         load;
  if_id_t       load_data;
  if_id_t       if_id;

  assign redir    = trap_taken | br_taken;
  assign target   = trap_taken ? {trap_target[31:2], 2'b00} : {br_target[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    req       = 1'b0;
    imem_addr = pc_q;
    load      = 1'b0;
    load_data = '{inst: imem_rdata, pc: pc_q, valid: 1'b1};
    case (state_q)
      ISSUE: begin
        if (redir) begin
          pc_d = target;
        end else begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redir) begin
            pc_d    = target;
            state_d = ISSUE;
          end else if (stall_d) begin
            buf_d   = imem_rdata;
            state_d = HELD;
          end else begin
            // Hand the word to decode and issue the next fetch in the same cycle.
            load      = 1'b1;
            req       = 1'b1;
            imem_addr = pc_plus4;
            pc_d      = pc_plus4;
          end
        end else if (redir) begin
          pc_d    = target;
          state_d = DROP;
        end
      end
      HELD: begin
        if (redir) begin
          pc_d    = target;
          state_d = ISSUE;
        end else if (!stall_d) begin
          load           = 1'b1;
          load_data.inst = buf_q;
          req            = 1'b1;
          imem_addr      = pc_plus4;
          pc_d           = pc_plus4;
          state_d        = WAIT;
        end
      end
      DROP: begin
        // The stale response still terminates the outstanding request even if redirected again.
        if (redir) pc_d = target;
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  assign imem_req = req & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      buf_q   <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redir),
    .stall_i    (stall_d),
    .load_i     (load),
    .load_data_i(load_data),
    .if_id_o    (if_id)
  );

  assign if_id_inst  = if_id.inst;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;

endmodule
